// File: rtl/demux32_1to2_buf.sv
// Purpose: registered 1-to-2 word demux with per-lane zeroing and per-port delivery counters.
// Latency: 1 cycle from input accept to outX_valid; in_ready is combinational.
// Backpressure: each port holds one word; a full, stalled port deasserts in_ready for words steered to it.
module demux32_1to2_buf #(
  parameter int WIDTH = 32,  // must be a multiple of 8
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               select,
  input  logic [WIDTH/8-1:0] byte_en,
  output logic               out0_valid,
  input  logic               out0_ready,
  output logic [WIDTH-1:0]   out0_data,
  output logic               out1_valid,
  input  logic               out1_ready,
  output logic [WIDTH-1:0]   out1_data,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
);

  localparam int NB = WIDTH / 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } port_st_t;

  port_st_t         r_st0, r_st1;
  port_st_t         w_st0_nxt, w_st1_nxt;
  logic [WIDTH-1:0] r_data0, r_data1;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;
  logic [WIDTH-1:0] w_masked;
  logic             w_accept, w_load0, w_load1, w_drain0, w_drain1;

  // Lane mask applied to the incoming word only; held words are never re-masked.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) begin
        w_masked[8*i +: 8] = in_data[8*i +: 8];
      end
    end
  end

  assign out0_valid = (r_st0 == ST_FULL);
  assign out1_valid = (r_st1 == ST_FULL);
  assign out0_data  = r_data0;
  assign out1_data  = r_data1;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

  assign w_drain0 = out0_valid && out0_ready;
  assign w_drain1 = out1_valid && out1_ready;

  // Selected port can take a word if empty or draining this cycle; held low during reset.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (select) begin
        in_ready = !out1_valid || out1_ready;
      end else begin
        in_ready = !out0_valid || out0_ready;
      end
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_load0  = w_accept && !select;
  assign w_load1  = w_accept && select;

  // Per-port next state: a load wins over a drain so back-to-back words keep valid high.
  always_comb begin
    w_st0_nxt = r_st0;
    w_st1_nxt = r_st1;
    if (w_load0) begin
      w_st0_nxt = ST_FULL;
    end else if (w_drain0) begin
      w_st0_nxt = ST_EMPTY;
    end
    if (w_load1) begin
      w_st1_nxt = ST_FULL;
    end else if (w_drain1) begin
      w_st1_nxt = ST_EMPTY;
    end
  end

  // Port state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st0 <= ST_EMPTY;
      r_st1 <= ST_EMPTY;
    end else begin
      r_st0 <= w_st0_nxt;
      r_st1 <= w_st1_nxt;
    end
  end

  // Holding registers load only on accept; a drained word's data is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      if (w_load0) begin
        r_data0 <= w_masked;
      end
      if (w_load1) begin
        r_data1 <= w_masked;
      end
    end
  end

  // Delivery counters: count completed output handshakes, clear has priority, wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (clr_cnt) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_drain0) begin
        r_cnt0 <= r_cnt0 + 1'b1;
      end
      if (w_drain1) begin
        r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux32_1to2_buf.sv
// Purpose: directed self-checking bench for demux32_1to2_buf.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises stalls, simultaneous drain/load, streaming and async reset.
module tb_demux32_1to2_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        select;
  logic [3:0]  byte_en;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
  logic        clr_cnt;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int n_checks = 0;
  int n_errors = 0;

  demux32_1to2_buf #(.WIDTH(32), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .select     (select),
    .byte_en    (byte_en),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .clr_cnt    (clr_cnt),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_rdy;
    int bad_dat;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 32'h0;
    select     = 1'b0;
    byte_en    = 4'h0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    clr_cnt    = 1'b0;
    #2;
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_out0_data",  out0_data,  0);
    check("rst_out1_data",  out1_data,  0);
    check("rst_cnt0",       cnt0,       0);
    check("rst_cnt1",       cnt1,       0);
    check("rst_in_ready",   in_ready,   0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // Basic route to port 1.
    in_valid = 1'b1; in_data = 32'hDEADBEEF; select = 1'b1; byte_en = 4'hF;
    out1_ready = 1'b1;
    #1;
    check("basic_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("basic_out1_valid", out1_valid, 1);
    check("basic_out1_data",  out1_data,  32'hDEADBEEF);
    check("basic_out0_valid", out0_valid, 0);
    tick;
    check("basic_cnt1",        cnt1,       1);
    check("basic_cnt0",        cnt0,       0);
    check("basic_drained",     out1_valid, 0);
    check("basic_retain_data", out1_data,  32'hDEADBEEF);

    // Lane masking on port 0.
    out0_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h11223344; select = 1'b0; byte_en = 4'b0101;
    tick;
    in_valid = 1'b0;
    check("mask_out0_valid", out0_valid, 1);
    check("mask_out0_data",  out0_data,  32'h00220044);
    tick;
    check("mask_cnt0", cnt0, 1);

    // Clear counters before the backpressure case.
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    check("clr_cnt0", cnt0, 0);
    check("clr_cnt1", cnt1, 0);

    // Backpressure on port 0, with port 1 serviced while port 0 holds.
    out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; select = 1'b0; byte_en = 4'hF;
    tick;
    in_data = 32'hB;
    #1;
    check("bp_in_ready_stalled", in_ready, 0);
    tick;
    check("bp_hold_data",  out0_data,  32'hA);
    check("bp_hold_valid", out0_valid, 1);
    in_data = 32'h5; select = 1'b1; out1_ready = 1'b1;
    #1;
    check("indep_in_ready", in_ready, 1);
    tick;
    in_data = 32'hB; select = 1'b0;
    check("indep_out1_valid", out1_valid, 1);
    check("indep_out1_data",  out1_data,  32'h5);
    check("indep_out0_hold",  out0_data,  32'hA);
    out0_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("bp_swap_valid", out0_valid, 1);
    check("bp_swap_data",  out0_data,  32'hB);
    check("bp_cnt0_one",   cnt0,       1);
    check("indep_cnt1",    cnt1,       1);
    tick;
    check("bp_cnt0_two",   cnt0,       2);
    check("bp_empty",      out0_valid, 0);

    // Streaming 256 words to port 1 and counter wrap.
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    bad_rdy = 0;
    bad_dat = 0;
    in_valid = 1'b1; select = 1'b1; byte_en = 4'hF; out1_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 32'(i) ^ 32'h5A000000;
      #1;
      if (in_ready !== 1'b1) bad_rdy++;
      tick;
      if (out1_valid !== 1'b1 || out1_data !== (32'(i) ^ 32'h5A000000)) bad_dat++;
    end
    in_valid = 1'b0;
    check("stream_in_ready_misses", bad_rdy, 0);
    check("stream_data_misses",     bad_dat, 0);
    check("stream_cnt1_255",        cnt1,    255);
    tick;
    check("stream_cnt1_wrap", cnt1,       0);
    check("stream_empty",     out1_valid, 0);

    // Clear takes priority over a same-cycle handshake.
    in_valid = 1'b1; in_data = 32'h77; select = 1'b1;
    tick;
    in_valid = 1'b0;
    check("clrprio_loaded", out1_valid, 1);
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    check("clrprio_cnt1",  cnt1,       0);
    check("clrprio_drain", out1_valid, 0);

    // Async reset with both ports full.
    out0_ready = 1'b1; out1_ready = 1'b0;
    in_valid = 1'b1; select = 1'b0; in_data = 32'hE0;
    tick;
    in_data = 32'hC0;
    tick;
    out0_ready = 1'b0;
    select = 1'b1; in_data = 32'hC1;
    tick;
    in_valid = 1'b0;
    check("ar_pre_out0_valid", out0_valid, 1);
    check("ar_pre_out1_valid", out1_valid, 1);
    check("ar_pre_cnt0",       cnt0,       1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out0_valid", out0_valid, 0);
    check("ar_out1_valid", out1_valid, 0);
    check("ar_out0_data",  out0_data,  0);
    check("ar_out1_data",  out1_data,  0);
    check("ar_cnt0",       cnt0,       0);
    check("ar_in_ready",   in_ready,   0);
    #2;
    rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick;
    tick;
    check("ar_post_out0_valid", out0_valid, 0);
    check("ar_post_out1_valid", out1_valid, 0);
    check("ar_post_cnt0",       cnt0,       0);
    check("ar_post_cnt1",       cnt1,       0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux32_1to2_buf.md
Name: demux32_1to2_buf

Overview:
- Registered 1-to-2 demultiplexer for 32-bit datapath words; the inverse of the team's 2-to-1 word mux.
- Steers one valid/ready input stream to one of two valid/ready output ports, e.g. the writeback result to the register file or the store path.
- Each output has a one-entry holding register with backpressure.
- Byte lanes are handled per 8-bit slice with optional zeroing.
- Per-port delivered-word counters support lab debug.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- CNT_W, 8, width of each per-port delivery counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid is also high.
- in_data  input  WIDTH  input word.
- select  input  1  destination: 0 routes to port 0, 1 routes to port 1.
- byte_en  input  WIDTH/8  per-lane enable; a disabled lane is delivered as 8'h00.
- out0_valid  output  1  port 0 holds a word.
- out0_ready  input  1  port 0 consumer accepts.
- out0_data  output  WIDTH  port 0 word.
- out1_valid  output  1  port 1 holds a word.
- out1_ready  input  1  port 1 consumer accepts.
- out1_data  output  WIDTH  port 1 word.
- clr_cnt  input  1  synchronous clear of both counters.
- cnt0  output  CNT_W  count of completed port-0 handshakes.
- cnt1  output  CNT_W  count of completed port-1 handshakes.

Behaviour:
- Reset (rst_n low, asynchronous): out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0.
- Reset mid-operation: held words are discarded and no handshake is counted.
- Each port has two states, EMPTY (valid=0) and FULL (valid=1).
- in_ready is combinational from select, the selected port's valid, and that port's ready:
  - select=0: in_ready = !out0_valid || out0_ready.
  - select=1: in_ready = !out1_valid || out1_ready.
- in_ready does not depend on in_valid. It is forced 0 while rst_n is low.
- Accept (in_valid && in_ready): on the next rising edge, the selected port register loads the masked word and its valid goes 1.
- Latency is exactly 1 cycle from accept to outX_valid.
- The non-selected port is unaffected.
- Masking: lane i of the output word = in_data[8i+7:8i] if byte_en[i]=1, else 0. Applied at load time, never on the held value.
- Drain (outX_valid && outX_ready): valid clears on the next edge unless the same port is loaded in the same cycle.
- Simultaneous drain and load of the same port: the new word replaces the old and valid stays 1, giving full throughput of one word per cycle per port.
- Simultaneous drain of the other port is independent.
- Hold rule: while outX_valid && !outX_ready, outX_data is stable and the register is not overwritten. in_ready to that port is 0.
- Data retention: a drained register keeps its last data; only the valid bit clears.
- select and byte_en are don't-care when in_valid=0. in_data is not sampled unless an accept occurs.
- Counters:
  - cntX increments on each completed outX handshake and wraps from 2^CNT_W-1 to 0.
  - clr_cnt=1 zeroes both counters on the next edge and takes priority over a same-cycle increment.

Test Plan:
- Basic route: reset, then in_data=32'hDEADBEEF, select=1, byte_en=4'hF, out1_ready=1 → out1_valid high 1 cycle later with out1_data=32'hDEADBEEF; out0_valid stays 0; cnt1=1, cnt0=0.
- Lane masking: in_data=32'h11223344, byte_en=4'b0101, select=0 → out0_data=32'h00220044.
- Backpressure: out0_ready=0, send 32'hA to port 0, then 32'hB to port 0 → in_ready=0 on the second word and out0_data holds 32'hA. Raise out0_ready → 32'hA drains, 32'hB loads on the same edge, and cnt0 reaches 2 after both drain.
- Independent ports: port 0 stalled and full, send 32'h5 with select=1 → accepted immediately and delivered on port 1 while port 0 holds.
- Streaming and wrap: CNT_W=8, 256 back-to-back port-1 words with out1_ready=1 → in_ready stays 1 every cycle and cnt1 wraps to 0. Then assert clr_cnt together with a handshake → cnt1=0.
- Async reset mid-operation: both ports full, pulse rst_n low between clock edges → both valids and counters are 0 immediately with no clock; no stale word is delivered after release.
